// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one single-port unified memory between the
// instruction-fetch port and the data-memory port of a 5-stage pipeline.
// One access is in flight at a time: IDLE samples requests, ISSUE strobes
// the memory, WAIT counts down the read latency and captures read data,
// DONE pulses the completion valid of the granted port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (read only), held until if_valid
//   if_rdata/if_valid        fetched instruction and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata                 data request, held until dm_valid
//   dm_rdata/dm_valid        load data and one-cycle completion / store ack
//   mem_en/mem_we/mem_addr/
//   mem_wdata                registered memory strobe, write enable, address, data
//   mem_rdata                memory read data, valid MEM_LATENCY cycles after mem_en
//   stall_f/stall_m          pipeline holds for fetch and memory stages
//   busy                     arbiter is not idle
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_dm_q, last_dm_d;   // 1 = data port won the last grant
  logic        gnt_dm_q, gnt_dm_d;     // 1 = current transaction belongs to data port
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        busy_q, busy_d;
  logic        gnt_dm_s;

  // Next-state, grant selection, memory command and read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    gnt_dm_d    = gnt_dm_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    // Under contention the port that lost last time wins; a lone request wins outright.
    gnt_dm_s    = dm_req & (~if_req | ~last_dm_q);

    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          state_d   = ISSUE;
          cnt_d     = LAT;
          gnt_dm_d  = gnt_dm_s;
          last_dm_d = gnt_dm_s;
          mem_en_d  = 1'b1;
          if (gnt_dm_s) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 32'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        // Counter at zero marks the cycle in which mem_rdata is valid.
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          if_valid_d = ~gnt_dm_q;
          dm_valid_d = gnt_dm_q;
          if (gnt_dm_q) begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;   // store: load data register untouched
            end
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_dm_q   <= 1'b0;
      gnt_dm_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      gnt_dm_q    <= gnt_dm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

  // Stalls follow the raw requests so the pipeline holds in the request cycle itself.
  assign stall_f = if_req & ~if_valid_q;
  assign stall_m = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle table for the basic transactions, hand-written
// sequences for the latency-1 build and for alternating grants, and a random
// phase checked against a transaction-level timeline model of the arbiter.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] X0 = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Signals of the MEM_LATENCY = 2 instance
  logic rst, if_req, dm_req, dm_we, if_valid, dm_valid, mem_en, mem_we;
  logic stall_f, stall_m, busy;
  logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Signals of the MEM_LATENCY = 1 instance
  logic b_rst, b_if_req, b_dm_req, b_dm_we, b_if_valid, b_dm_valid, b_mem_en, b_mem_we;
  logic b_stall_f, b_stall_m, b_busy;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_if_rdata, b_dm_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_f(b_stall_f), .stall_m(b_stall_m), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One table row: ctl = {rst, if_req, dm_req, dm_we}; ef = {mem_en, mem_we, if_valid, dm_valid, busy}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] ia, da, dwd, mr;
    logic [4:0]  ef;
    logic [31:0] ma, mw, ird, drd;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] dwd, input logic [31:0] mr, input logic [4:0] ef,
                              input logic [31:0] ma, input logic [31:0] mw, input logic [31:0] ird,
                              input logic [31:0] drd);
    vec_t v;
    v.ctl = ctl; v.ia = ia; v.da = da; v.dwd = dwd; v.mr = mr;
    v.ef = ef; v.ma = ma; v.mw = mw; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  vec_t tbl[32];

  // Reference memory contents for the random phase (gold: model, mem_arr: responder)
  logic [31:0] gold [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  initial begin
    logic [31:0] alt_q[$];
    logic [31:0] alt_exp[4];
    logic        prev_en, cons;
    // timeline model state
    int          t, free_at, issue_at, done_at, rd_due;
    logic        last_dm, m_gnt_dm, m_we, saw_iv, saw_dv;
    logic [31:0] m_addr, m_wdata, m_exp, m_ird, m_drd, rd_val;

    // fetch 0x10, store 0x100, contended fetch+load after reset, reset mid-fetch
    tbl[0]  = mk(4'b0100, 32'h10, 32'h0,   32'h0,        X0,           5'b00000, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(4'b0100, 32'h10, 32'h0,   32'h0,        X0,           5'b10001, 32'h10,  32'h0,        32'h0,        32'h0);
    tbl[2]  = mk(4'b0100, 32'h10, 32'h0,   32'h0,        X0,           5'b00001, 32'h10,  32'h0,        32'h0,        32'h0);
    tbl[3]  = mk(4'b0100, 32'h10, 32'h0,   32'h0,        32'hDEADBEEF, 5'b00001, 32'h10,  32'h0,        32'h0,        32'h0);
    tbl[4]  = mk(4'b0100, 32'h10, 32'h0,   32'h0,        X0,           5'b00101, 32'h10,  32'h0,        32'hDEADBEEF, 32'h0);
    tbl[5]  = mk(4'b0000, 32'h0,  32'h0,   32'h0,        X0,           5'b00000, 32'h10,  32'h0,        32'hDEADBEEF, 32'h0);
    tbl[6]  = mk(4'b0011, 32'h0,  32'h100, 32'h12345678, X0,           5'b00000, 32'h10,  32'h0,        32'hDEADBEEF, 32'h0);
    tbl[7]  = mk(4'b0011, 32'h0,  32'h100, 32'h12345678, X0,           5'b11001, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[8]  = mk(4'b0011, 32'h0,  32'h100, 32'h12345678, X0,           5'b01001, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[9]  = mk(4'b0011, 32'h0,  32'h100, 32'h12345678, X0,           5'b01001, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[10] = mk(4'b0011, 32'h0,  32'h100, 32'h12345678, X0,           5'b01011, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[11] = mk(4'b1000, 32'h0,  32'h100, 32'h12345678, X0,           5'b01000, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[12] = mk(4'b0110, 32'h40, 32'h200, 32'h0,        X0,           5'b00000, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[13] = mk(4'b0110, 32'h40, 32'h200, 32'h0,        X0,           5'b10001, 32'h200, 32'h0,        32'h0,        32'h0);
    tbl[14] = mk(4'b0110, 32'h40, 32'h200, 32'h0,        X0,           5'b00001, 32'h200, 32'h0,        32'h0,        32'h0);
    tbl[15] = mk(4'b0110, 32'h40, 32'h200, 32'h0,        32'hCAFEF00D, 5'b00001, 32'h200, 32'h0,        32'h0,        32'h0);
    tbl[16] = mk(4'b0110, 32'h40, 32'h200, 32'h0,        X0,           5'b00011, 32'h200, 32'h0,        32'h0,        32'hCAFEF00D);
    tbl[17] = mk(4'b0100, 32'h40, 32'h200, 32'h0,        X0,           5'b00000, 32'h200, 32'h0,        32'h0,        32'hCAFEF00D);
    tbl[18] = mk(4'b0100, 32'h40, 32'h200, 32'h0,        X0,           5'b10001, 32'h40,  32'h0,        32'h0,        32'hCAFEF00D);
    tbl[19] = mk(4'b0100, 32'h40, 32'h200, 32'h0,        X0,           5'b00001, 32'h40,  32'h0,        32'h0,        32'hCAFEF00D);
    tbl[20] = mk(4'b0100, 32'h40, 32'h200, 32'h0,        32'h0BADC0DE, 5'b00001, 32'h40,  32'h0,        32'h0,        32'hCAFEF00D);
    tbl[21] = mk(4'b0100, 32'h40, 32'h200, 32'h0,        X0,           5'b00101, 32'h40,  32'h0,        32'h0BADC0DE, 32'hCAFEF00D);
    tbl[22] = mk(4'b0000, 32'h0,  32'h0,   32'h0,        X0,           5'b00000, 32'h40,  32'h0,        32'h0BADC0DE, 32'hCAFEF00D);
    tbl[23] = mk(4'b0100, 32'h80, 32'h0,   32'h0,        X0,           5'b00000, 32'h40,  32'h0,        32'h0BADC0DE, 32'hCAFEF00D);
    tbl[24] = mk(4'b0100, 32'h80, 32'h0,   32'h0,        X0,           5'b10001, 32'h80,  32'h0,        32'h0BADC0DE, 32'hCAFEF00D);
    tbl[25] = mk(4'b1100, 32'h80, 32'h0,   32'h0,        X0,           5'b00001, 32'h80,  32'h0,        32'h0BADC0DE, 32'hCAFEF00D);
    tbl[26] = mk(4'b0100, 32'h90, 32'h0,   32'h0,        32'h11111111, 5'b00000, 32'h0,   32'h0,        32'h0,        32'h0);
    tbl[27] = mk(4'b0100, 32'h90, 32'h0,   32'h0,        X0,           5'b10001, 32'h90,  32'h0,        32'h0,        32'h0);
    tbl[28] = mk(4'b0100, 32'h90, 32'h0,   32'h0,        X0,           5'b00001, 32'h90,  32'h0,        32'h0,        32'h0);
    tbl[29] = mk(4'b0100, 32'h90, 32'h0,   32'h0,        32'h22222222, 5'b00001, 32'h90,  32'h0,        32'h0,        32'h0);
    tbl[30] = mk(4'b0100, 32'h90, 32'h0,   32'h0,        X0,           5'b00101, 32'h90,  32'h0,        32'h22222222, 32'h0);
    tbl[31] = mk(4'b0000, 32'h0,  32'h0,   32'h0,        X0,           5'b00000, 32'h90,  32'h0,        32'h22222222, 32'h0);

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = 32'h0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_dm_addr = 32'h0; b_dm_wdata = 32'h0; b_mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 b_rst = 1'b0;

    // ---- cycle table on the latency-2 instance ----
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].ctl[3]; if_req = tbl[i].ctl[2]; dm_req = tbl[i].ctl[1]; dm_we = tbl[i].ctl[0];
      if_addr = tbl[i].ia; dm_addr = tbl[i].da; dm_wdata = tbl[i].dwd; mem_rdata = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("row%0d mem_en", i),    32'(mem_en),    32'(tbl[i].ef[4]));
      chk($sformatf("row%0d mem_we", i),    32'(mem_we),    32'(tbl[i].ef[3]));
      chk($sformatf("row%0d mem_addr", i),  mem_addr,       tbl[i].ma);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,      tbl[i].mw);
      chk($sformatf("row%0d if_valid", i),  32'(if_valid),  32'(tbl[i].ef[2]));
      chk($sformatf("row%0d if_rdata", i),  if_rdata,       tbl[i].ird);
      chk($sformatf("row%0d dm_valid", i),  32'(dm_valid),  32'(tbl[i].ef[1]));
      chk($sformatf("row%0d dm_rdata", i),  dm_rdata,       tbl[i].drd);
      chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].ef[0]));
      chk($sformatf("row%0d stall_f", i),   32'(stall_f),   32'(tbl[i].ctl[2] & ~tbl[i].ef[2]));
      chk($sformatf("row%0d stall_m", i),   32'(stall_m),   32'(tbl[i].ctl[1] & ~tbl[i].ef[1]));
    end

    // ---- latency-1 build: fetch at cycle 0 ----
    @(posedge clk); #1 b_if_req = 1'b1; b_if_addr = 32'h30; b_mem_rdata = X0;
    @(negedge clk);
    chk("l1 c0 mem_en", 32'(b_mem_en), 32'd0);
    chk("l1 c0 stall_f", 32'(b_stall_f), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1 c1 mem_en", 32'(b_mem_en), 32'd1);
    chk("l1 c1 mem_addr", b_mem_addr, 32'h30);
    chk("l1 c1 mem_we", 32'(b_mem_we), 32'd0);
    @(posedge clk); #1 b_mem_rdata = 32'hA1B2C3D4;
    @(negedge clk);
    chk("l1 c2 mem_en", 32'(b_mem_en), 32'd0);
    chk("l1 c2 if_valid", 32'(b_if_valid), 32'd0);
    chk("l1 c2 busy", 32'(b_busy), 32'd1);
    @(posedge clk); #1 b_mem_rdata = X0;
    @(negedge clk);
    chk("l1 c3 if_valid", 32'(b_if_valid), 32'd1);
    chk("l1 c3 if_rdata", b_if_rdata, 32'hA1B2C3D4);
    chk("l1 c3 stall_f", 32'(b_stall_f), 32'd0);
    @(posedge clk); #1 b_if_req = 1'b0;
    @(negedge clk);
    chk("l1 c4 if_valid", 32'(b_if_valid), 32'd0);
    chk("l1 c4 busy", 32'(b_busy), 32'd0);

    // ---- both ports continuously requesting: grants alternate data, fetch ----
    @(posedge clk); #1 rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    alt_exp[0] = 32'h400; alt_exp[1] = 32'h300; alt_exp[2] = 32'h400; alt_exp[3] = 32'h300;
    prev_en = 1'b0; cons = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      rst = 1'b0; if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_we = 1'b0;
      dm_addr = 32'h400; dm_wdata = 32'h0; mem_rdata = $urandom;
      @(negedge clk);
      if (mem_en) alt_q.push_back(mem_addr);
      if (mem_en && prev_en) cons = 1'b1;
      prev_en = mem_en;
      if (alt_q.size() == 4) break;
    end
    chk("alt grant count", 32'(alt_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < alt_q.size()) chk($sformatf("alt grant %0d", k), alt_q[k], alt_exp[k]);
    end
    chk("alt back-to-back mem_en", 32'(cons), 32'd0);

    // ---- random traffic against a timeline model ----
    @(posedge clk); #1 rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    free_at = 0; issue_at = -10; done_at = -10; rd_due = -10;
    last_dm = 1'b0; m_gnt_dm = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_exp = 32'h0; m_ird = 32'h0; m_drd = 32'h0; rd_val = 32'h0;
    saw_iv = 1'b0; saw_dv = 1'b0;
    for (t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (saw_iv || (if_req && $urandom_range(15) == 0)) if_req = 1'b0;
      else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = 32'($urandom_range(7)) << 2;
      end
      if (saw_dv || (dm_req && $urandom_range(15) == 0)) dm_req = 1'b0;
      else if (!dm_req && $urandom_range(2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(1));
        dm_addr = 32'($urandom_range(7)) << 2; dm_wdata = $urandom;
      end
      @(negedge clk);
      // memory responder: read data only in its due cycle, noise otherwise
      mem_rdata = (t == rd_due) ? rd_val : $urandom;
      // model: completion makes the captured value visible in the DONE cycle
      if (t == done_at) begin
        if (!m_gnt_dm) m_ird = m_exp;
        else if (!m_we) m_drd = m_exp;
      end
      chk($sformatf("rnd t%0d mem_en", t),   32'(mem_en),   32'(t == issue_at));
      if (t == issue_at) begin
        chk($sformatf("rnd t%0d mem_addr", t),  mem_addr,  m_addr);
        chk($sformatf("rnd t%0d mem_we", t),    32'(mem_we), 32'(m_we));
        chk($sformatf("rnd t%0d mem_wdata", t), mem_wdata, m_wdata);
      end
      chk($sformatf("rnd t%0d if_valid", t), 32'(if_valid), 32'(t == done_at && !m_gnt_dm));
      chk($sformatf("rnd t%0d dm_valid", t), 32'(dm_valid), 32'(t == done_at && m_gnt_dm));
      chk($sformatf("rnd t%0d if_rdata", t), if_rdata, m_ird);
      chk($sformatf("rnd t%0d dm_rdata", t), dm_rdata, m_drd);
      chk($sformatf("rnd t%0d busy", t),     32'(busy), 32'(t >= issue_at && t <= done_at));
      chk($sformatf("rnd t%0d stall_f", t),  32'(stall_f), 32'(if_req && !(t == done_at && !m_gnt_dm)));
      chk($sformatf("rnd t%0d stall_m", t),  32'(stall_m), 32'(dm_req && !(t == done_at && m_gnt_dm)));
      // model: idle arbiter takes a request, alternating under contention
      if (t >= free_at && (if_req || dm_req)) begin
        m_gnt_dm = dm_req && (!if_req || !last_dm);
        last_dm  = m_gnt_dm;
        m_we     = m_gnt_dm ? dm_we : 1'b0;
        m_addr   = m_gnt_dm ? dm_addr : if_addr;
        m_wdata  = m_gnt_dm ? dm_wdata : 32'h0;
        if (m_we) gold[m_addr] = m_wdata;
        else m_exp = gold.exists(m_addr) ? gold[m_addr] : dflt(m_addr);
        issue_at = t + 1;
        done_at  = t + LAT + 2;
        free_at  = t + LAT + 3;
      end
      // memory responder acts on the strobe it actually sees
      if (mem_en) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else begin
          rd_due = t + LAT;
          rd_val = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
        end
      end
      saw_iv = if_valid;
      saw_dv = dm_valid;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
